// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage: sample format, alert states
// and the saturating magnitude helper.
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int Q_FORMAT   = 8;
    localparam int SCALE      = 1 << Q_FORMAT;

    typedef enum logic {
        NORMAL = 1'b0,
        ALERT  = 1'b1
    } alert_state_t;

    // Two's-complement negation of the most-negative value overflows, so clamp it.
    function automatic logic [DATA_WIDTH-1:0] satAbs(input logic signed [DATA_WIDTH-1:0] value);
        logic [DATA_WIDTH-1:0] result;
        if (!value[DATA_WIDTH-1]) begin
            result = value;
        end else if (value == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            result = -value;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_alert_fsm.sv
// Hysteresis alert: ALERT_RUN consecutive over samples enter ALERT,
// ALERT_RUN consecutive under samples leave it.
module fir_alert_fsm
    import fir_pkg::*;
#(
    parameter int ALERT_RUN = 3
) (
    input  logic clk,
    input  logic rstN,
    input  logic clr,
    input  logic sampleAccepted,
    input  logic over,
    output logic alert
);

    localparam int RUN_W = $clog2(ALERT_RUN + 1);

    alert_state_t state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic qualifying;

    assign run_inc = run + RUN_W'(1);
    // A sample "qualifies" when it pushes toward leaving the current state.
    assign qualifying = (state == NORMAL) ? over : !over;
    assign alert = (state == ALERT);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= NORMAL;
            run   <= '0;
        end else if (clr) begin
            state <= NORMAL;
            run   <= '0;
        end else if (sampleAccepted) begin
            if (!qualifying) begin
                run <= '0;
            end else if (run_inc == RUN_W'(ALERT_RUN)) begin
                state <= (state == NORMAL) ? ALERT : NORMAL;
                run   <= '0;
            end else begin
                run <= run_inc;
            end
        end
    end

endmodule

// File: rtl/fir_result_buffer.sv
// Circular FIFO capturing FIR results for the host, with drop accounting
// and an over-threshold alert on every accepted sample.
module fir_result_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ALERT_RUN  = 3,
    parameter int DROP_W     = 8
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         clrBuf,
    input  logic [DATA_WIDTH-1:0]        macResult,
    input  logic                         resultIsValid,
    input  logic [DATA_WIDTH-1:0]        threshold,
    output logic [DATA_WIDTH-1:0]        outData,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [DROP_W-1:0]            dropCount,
    output logic                         alert
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [DATA_WIDTH-1:0] magnitude;
    logic                  over;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign outValid = !empty;
    // Gated so a drained or freshly reset FIFO shows zero, not stale storage.
    assign outData  = outValid ? mem[rd_ptr] : '0;

    assign pop     = outValid && outReady;
    assign push_ok = resultIsValid && (!full || pop);
    assign drop    = resultIsValid && full && !pop;

    assign magnitude = satAbs(macResult);
    assign over      = magnitude > threshold;

    always_ff @(posedge clk) begin
        if (push_ok && !clrBuf) begin
            mem[wr_ptr] <= macResult;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (clrBuf) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (dropCount != '1) begin
                    dropCount <= dropCount + DROP_W'(1);
                end
            end
        end
    end

    fir_alert_fsm #(
        .ALERT_RUN(ALERT_RUN)
    ) u_alert_fsm (
        .clk           (clk),
        .rstN          (rstN),
        .clr           (clrBuf),
        .sampleAccepted(push_ok && !clrBuf),
        .over          (over),
        .alert         (alert)
    );

endmodule

// File: tb/tb_fir_result_buffer.sv
// Directed bench for fir_result_buffer: FIFO order, overflow, alert
// hysteresis, saturation, clear and asynchronous reset.
module tb_fir_result_buffer;

    logic        clk;
    logic        rstN;
    logic        clrBuf;
    logic [15:0] macResult;
    logic        resultIsValid;
    logic [15:0] threshold;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  dropCount;
    logic        alert;

    int checks = 0;
    int errors = 0;

    fir_result_buffer dut (
        .clk          (clk),
        .rstN         (rstN),
        .clrBuf       (clrBuf),
        .macResult    (macResult),
        .resultIsValid(resultIsValid),
        .threshold    (threshold),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .dropCount    (dropCount),
        .alert        (alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clrBuf = 1'b1;
        tick();
        clrBuf = 1'b0;
    endtask

    task automatic push(input logic [15:0] value);
        macResult     = value;
        resultIsValid = 1'b1;
        tick();
        resultIsValid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
        checks++; if (outData !== 16'h0000) begin errors++; $display("FAIL reset_outData got %h want 0000", outData); end
        checks++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin errors++; $display("FAIL reset_drop got ovf=%b cnt=%0d want 0/0", overflow, dropCount); end
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL reset_alert got %b want 0", alert); end
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_push_three();
        outReady = 1'b0;
        push(16'h0033);
        checks++; if (outValid !== 1'b1 || outData !== 16'h0033) begin errors++; $display("FAIL first_latency got v=%b d=%h want 1/0033", outValid, outData); end
        push(16'h0033);
        push(16'h0033);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL three_count got %0d want 3", count); end
        checks++; if (outData !== 16'h0033 || outValid !== 1'b1) begin errors++; $display("FAIL three_head got v=%b d=%h want 1/0033", outValid, outData); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL three_empty got %b want 0", empty); end
        do_clear();
    endtask

    task automatic test_overflow();
        outReady = 1'b0;
        for (int i = 0; i < 10; i++) push(16'h0010 + 16'(i));
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_full got full=%b cnt=%0d want 1/8", full, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (dropCount !== 8'd2) begin errors++; $display("FAIL ovf_dropCount got %0d want 2", dropCount); end
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (outData !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL drain_%0d got %h want %h", i, outData, 16'h0010 + 16'(i)); end
            tick();
        end
        outReady = 1'b0;
        checks++; if (empty !== 1'b1 || outValid !== 1'b0) begin errors++; $display("FAIL drain_empty got e=%b v=%b want 1/0", empty, outValid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expected;
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i));
        macResult     = 16'h0100;
        resultIsValid = 1'b1;
        outReady      = 1'b1;
        tick();
        resultIsValid = 1'b0;
        outReady      = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL b2b_count got %0d want 8", count); end
        checks++; if (dropCount !== 8'd2) begin errors++; $display("FAIL b2b_dropCount got %0d want 2", dropCount); end
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expected = (i == 7) ? 16'h0100 : 16'h0021 + 16'(i);
            checks++; if (outData !== expected) begin errors++; $display("FAIL b2b_drain_%0d got %h want %h", i, outData, expected); end
            tick();
        end
        outReady = 1'b0;
    endtask

    task automatic test_alert();
        logic [15:0] samples [9] = '{16'h0300, 16'hFC00, 16'h0280, 16'h0100, 16'h0100,
                                     16'h0300, 16'h0000, 16'h0000, 16'h0000};
        logic        expected [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_clear();
        threshold = 16'h0200;
        outReady  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(samples[i]);
            checks++; if (alert !== expected[i]) begin errors++; $display("FAIL alert_step_%0d got %b want %b", i, alert, expected[i]); end
        end
    endtask

    task automatic test_saturation();
        logic expected [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_clear();
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            threshold = (i < 3) ? 16'h7FFE : 16'h7FFF;
            push(16'h8000);
            checks++; if (alert !== expected[i]) begin errors++; $display("FAIL sat_step_%0d got %b want %b", i, alert, expected[i]); end
        end
    endtask

    task automatic test_clear_and_reset();
        do_clear();
        threshold = 16'hFFFF;
        outReady  = 1'b0;
        for (int i = 0; i < 10; i++) push(16'h0040 + 16'(i));
        checks++; if (overflow !== 1'b1 || dropCount !== 8'd2) begin errors++; $display("FAIL pre_clear got ovf=%b cnt=%0d want 1/2", overflow, dropCount); end
        macResult     = 16'h0055;
        resultIsValid = 1'b1;
        clrBuf        = 1'b1;
        tick();
        clrBuf        = 1'b0;
        resultIsValid = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || outValid !== 1'b0) begin errors++; $display("FAIL clear_count got cnt=%0d e=%b v=%b want 0/1/0", count, empty, outValid); end
        checks++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin errors++; $display("FAIL clear_drop got ovf=%b cnt=%0d want 0/0", overflow, dropCount); end
        for (int i = 0; i < 3; i++) push(16'h0060 + 16'(i));
        checks++; if (count !== 4'd3 || outData !== 16'h0060) begin errors++; $display("FAIL post_clear got cnt=%0d d=%h want 3/0060", count, outData); end
        rstN = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL async_reset got v=%b cnt=%0d want 0/0", outValid, count); end
        checks++; if (outData !== 16'h0000) begin errors++; $display("FAIL async_reset_data got %h want 0000", outData); end
        tick();
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        rstN          = 1'b0;
        clrBuf        = 1'b0;
        macResult     = '0;
        resultIsValid = 1'b0;
        threshold     = 16'hFFFF;
        outReady      = 1'b0;
        test_reset();
        test_push_three();
        test_overflow();
        test_back_to_back();
        test_alert();
        test_saturation();
        test_clear_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
